radix2_seq_divider: RTL and testbench
=====================================

// Module: radix2_seq_divider
// PURPOSE
//  Iterative radix-2 non-restoring integer divider: inverse datapath of the Booth-4/Wallace multiplier.
//  Takes a dividend/divisor pair with per-operand signedness; returns quotient and remainder (RV32M semantics).
//  Valid/ready on both sides. Sits beside the multiplier in the M-extension execute unit.
// PARAMETERS
//  DIV_SIZE   32           operand/result width in bits (even, >= 4)
//  CNT_WIDTH  $clog2(DIV_SIZE)+1   iteration counter width (derived; do not override)
// PORTS
//  in_clk             in   1         clock, rising edge
//  in_rst_n           in   1         asynchronous active-low reset
//  in_valid           in   1         request valid
//  out_ready          out  1         divider can accept (high only in IDLE)
//  in_dividend        in   DIV_SIZE  dividend
//  in_divisor         in   DIV_SIZE  divisor
//  in_dividend_signed in   1         1: dividend is two's complement
//  in_divisor_signed  in   1         1: divisor is two's complement
//  out_valid          out  1         result valid (high only in DONE)
//  in_ready           in   1         consumer accepts result
//  out_quotient       out  DIV_SIZE  quotient, truncated toward zero
//  out_remainder      out  DIV_SIZE  remainder, sign follows dividend
//  out_div_by_zero    out  1         divisor was zero
// BEHAVIOUR
//  Reset: state=IDLE; out_ready=1 (combinational from IDLE); out_valid=0; out_quotient, out_remainder,
//   out_div_by_zero and all internal registers = 0. Reset mid-operation discards the job with no output.
//  FSM: IDLE -> CALC on accept (in_valid & out_ready); IDLE -> DONE on accept with divisor==0;
//   CALC -> FIX after DIV_SIZE iterations; FIX -> DONE; DONE -> IDLE on in_valid... no: on in_ready.
//   DONE -> IDLE strictly on out_valid & in_ready. in_valid is ignored outside IDLE.
//  Accept cycle (edge 0): latch effective signs (sign = signed flag & MSB).
//   Latch magnitudes |a|, |b| as DIV_SIZE-bit unsigned (|0x80..0| = 2^(N-1), no overflow).
//   Latch q_neg = sign_a ^ sign_b and r_neg = sign_a. Clear counter.
//  CALC: one quotient bit per cycle. Partial remainder P is DIV_SIZE+1 bits, signed.
//   Per step: {P,Q} <<= 1. If P>=0 then P -= |b|, else P += |b|. Q[0] = ~P_new[MSB].
//   Exactly DIV_SIZE cycles.
//  FIX (1 cycle): if P<0 then P += |b|. Conditionally negate Q by q_neg and P by r_neg.
//   Register out_quotient/out_remainder.
//  Latency: accept at edge 0 -> out_valid high at cycle DIV_SIZE+2. Throughput: one op per DIV_SIZE+3 cycles minimum.
//  Divide-by-zero: out_quotient = all ones, out_remainder = in_dividend as given (unmodified),
//   out_div_by_zero=1, out_valid at cycle 1. out_div_by_zero=0 for all other results.
//  Signed overflow (MIN / -1): falls out of the datapath: quotient = MIN, remainder = 0, no flag.
//  Outputs held stable while out_valid & ~in_ready. out_ready is never high in the same cycle as out_valid.
//  Unsigned operands with MSB=1 are treated as magnitudes (no sign extension).
// STRUCTURE
//  Package div_pkg: typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE} div_state_t.
//  Sub-module div_cond_negate #(WIDTH): out = neg ? ~in + 1 : in. Instantiate four times:
//   |a|, |b|, quotient fix-up, remainder fix-up.
//  Main block: FSM, iteration counter, P/Q shift registers, add/sub of width DIV_SIZE+1.
// TESTING (DIV_SIZE=32; cycle counts from accept edge)
//  1 Unsigned 100 / 7 -> q=14, r=2, div0=0. out_valid first high at cycle 34; out_ready=0 cycles 1..34.
//  2 Signed -7 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / -2 -> q=0xFFFFFFFD, r=1.
//  3 Unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
//    Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, div0=0.
//  4 Divide-by-zero: 5 / 0 -> q=0xFFFFFFFF, r=5, div0=1, out_valid at cycle 1.
//    Signed -5 / 0 -> r=0xFFFFFFFB.
//  5 Backpressure: hold in_ready=0 for 5 cycles in DONE with in_valid=1 and new operands.
//    Outputs stable, no accept; on in_ready=1, IDLE next cycle and the pending request is accepted.
//  6 Assert in_rst_n=0 at cycle 10 of CALC. Outputs clear asynchronously, out_ready=1 after release.
//    Next request 1000 / 10 -> q=100, r=0.

Source files
------------

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared types for the radix-2 sequential divider.
//   div_state_t : divider control states
//     DIV_IDLE - waiting for a request (out_ready high)
//     DIV_CALC - one quotient bit per cycle
//     DIV_FIX  - remainder correction and sign fix-up
//     DIV_DONE - result presented (out_valid high)
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_cond_negate.sv
// ---------------------------------------------------------------------------
// div_cond_negate
//   Conditional two's complement negation: out_val = neg ? -in_val : in_val.
//   Ports:
//     neg     in   1      negate when high
//     in_val  in   WIDTH  operand
//     out_val out  WIDTH  result (wraps modulo 2^WIDTH)
// ---------------------------------------------------------------------------
module div_cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] out_val
);

    assign out_val = neg ? ((~in_val) + WIDTH'(1)) : in_val;

endmodule

// File: rtl/radix2_seq_divider.sv
// ---------------------------------------------------------------------------
// radix2_seq_divider
//   Iterative radix-2 non-restoring integer divider with RV32M semantics.
//   Quotient truncates toward zero, remainder takes the dividend's sign.
//   Ports:
//     in_clk, in_rst_n               clock / asynchronous active-low reset
//     in_valid, out_ready            request handshake (ready only in IDLE)
//     in_dividend, in_divisor        operands
//     in_dividend_signed/_divisor_signed  per-operand signedness
//     out_valid, in_ready            result handshake (valid only in DONE)
//     out_quotient, out_remainder    result
//     out_div_by_zero                divisor was zero
// ---------------------------------------------------------------------------
module radix2_seq_divider
    import div_pkg::*;
#(
    parameter int DIV_SIZE  = 32,
    parameter int CNT_WIDTH = $clog2(DIV_SIZE) + 1
) (
    input  logic                in_clk,
    input  logic                in_rst_n,
    input  logic                in_valid,
    output logic                out_ready,
    input  logic [DIV_SIZE-1:0] in_dividend,
    input  logic [DIV_SIZE-1:0] in_divisor,
    input  logic                in_dividend_signed,
    input  logic                in_divisor_signed,
    output logic                out_valid,
    input  logic                in_ready,
    output logic [DIV_SIZE-1:0] out_quotient,
    output logic [DIV_SIZE-1:0] out_remainder,
    output logic                out_div_by_zero
);

    div_state_t state, state_next;

    logic [CNT_WIDTH-1:0]       cnt;
    logic signed [DIV_SIZE:0]   p_reg;
    logic [DIV_SIZE-1:0]        q_reg;
    logic [DIV_SIZE-1:0]        b_mag;
    logic                       q_neg;
    logic                       r_neg;

    logic                       sign_a;
    logic                       sign_b;
    logic [DIV_SIZE-1:0]        a_mag_in;
    logic [DIV_SIZE-1:0]        b_mag_in;
    logic                       accept;
    logic                       div0_in;
    logic                       last_iter;

    logic signed [DIV_SIZE:0]   b_ext;
    logic signed [DIV_SIZE:0]   p_shift;
    logic signed [DIV_SIZE:0]   p_step;
    logic [DIV_SIZE-1:0]        r_mag;
    logic [DIV_SIZE-1:0]        q_fixed;
    logic [DIV_SIZE-1:0]        r_fixed;

    assign out_ready = (state == DIV_IDLE);
    assign out_valid = (state == DIV_DONE);

    assign sign_a    = in_dividend_signed & in_dividend[DIV_SIZE-1];
    assign sign_b    = in_divisor_signed  & in_divisor[DIV_SIZE-1];
    assign accept    = in_valid & out_ready;
    assign div0_in   = (in_divisor == '0);
    assign last_iter = (cnt == CNT_WIDTH'(DIV_SIZE - 1));

    // Magnitudes as unsigned DIV_SIZE-bit values; -MIN wraps to 2^(N-1),
    // which is exactly the right unsigned magnitude.
    div_cond_negate #(.WIDTH(DIV_SIZE)) u_neg_a (
        .neg(sign_a), .in_val(in_dividend), .out_val(a_mag_in)
    );
    div_cond_negate #(.WIDTH(DIV_SIZE)) u_neg_b (
        .neg(sign_b), .in_val(in_divisor), .out_val(b_mag_in)
    );

    // Non-restoring step. The shifted value can exceed the N+1-bit range,
    // but the post-add/sub result lies in [-b, b) so modular wrap is exact.
    assign b_ext   = signed'({1'b0, b_mag});
    assign p_shift = {p_reg[DIV_SIZE-1:0], q_reg[DIV_SIZE-1]};
    assign p_step  = p_reg[DIV_SIZE] ? (p_shift + b_ext) : (p_shift - b_ext);

    // Final correction lands in [0, b), so the low N bits carry the result.
    assign r_mag   = p_reg[DIV_SIZE] ? (p_reg[DIV_SIZE-1:0] + b_mag)
                                     : p_reg[DIV_SIZE-1:0];

    div_cond_negate #(.WIDTH(DIV_SIZE)) u_neg_q (
        .neg(q_neg), .in_val(q_reg), .out_val(q_fixed)
    );
    div_cond_negate #(.WIDTH(DIV_SIZE)) u_neg_r (
        .neg(r_neg), .in_val(r_mag), .out_val(r_fixed)
    );

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (accept) state_next = div0_in ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (last_iter) state_next = DIV_FIX;
            DIV_FIX:  state_next = DIV_DONE;
            DIV_DONE: if (in_ready) state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state           <= DIV_IDLE;
            cnt             <= '0;
            p_reg           <= '0;
            q_reg           <= '0;
            b_mag           <= '0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            out_quotient    <= '0;
            out_remainder   <= '0;
            out_div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        q_neg <= sign_a ^ sign_b;
                        r_neg <= sign_a;
                        b_mag <= b_mag_in;
                        p_reg <= '0;
                        q_reg <= a_mag_in;
                        cnt   <= '0;
                        // Zero divisor bypasses the datapath entirely.
                        if (div0_in) begin
                            out_quotient    <= '1;
                            out_remainder   <= in_dividend;
                            out_div_by_zero <= 1'b1;
                        end
                    end
                end
                DIV_CALC: begin
                    p_reg <= p_step;
                    q_reg <= {q_reg[DIV_SIZE-2:0], ~p_step[DIV_SIZE]};
                    cnt   <= cnt + CNT_WIDTH'(1);
                end
                DIV_FIX: begin
                    out_quotient    <= q_fixed;
                    out_remainder   <= r_fixed;
                    out_div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_radix2_seq_divider.sv
module tb_radix2_seq_divider;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] in_dividend;
    logic [N-1:0] in_divisor;
    logic         in_dividend_signed;
    logic         in_divisor_signed;
    logic         out_valid;
    logic         in_ready;
    logic [N-1:0] out_quotient;
    logic [N-1:0] out_remainder;
    logic         out_div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    radix2_seq_divider #(.DIV_SIZE(N)) dut (
        .in_clk             (clk),
        .in_rst_n           (rst_n),
        .in_valid           (in_valid),
        .out_ready          (out_ready),
        .in_dividend        (in_dividend),
        .in_divisor         (in_divisor),
        .in_dividend_signed (in_dividend_signed),
        .in_divisor_signed  (in_divisor_signed),
        .out_valid          (out_valid),
        .in_ready           (in_ready),
        .out_quotient       (out_quotient),
        .out_remainder      (out_remainder),
        .out_div_by_zero    (out_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RV32M division from plain integer arithmetic.
    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic sa, input logic sb,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic dz);
        longint av, bv, qv, rv;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
            return;
        end
        av = (sa && a[N-1]) ? longint'($signed(a)) : longint'({32'd0, a});
        bv = (sb && b[N-1]) ? longint'($signed(b)) : longint'({32'd0, b});
        qv = av / bv;
        rv = av % bv;
        q  = qv[N-1:0];
        r  = rv[N-1:0];
        dz = 1'b0;
    endfunction

    task automatic drive_req(input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic sa, input logic sb);
        in_dividend        = a;
        in_divisor         = b;
        in_dividend_signed = sa;
        in_divisor_signed  = sb;
        in_valid           = 1'b1;
    endtask

    // Called at the negedge right after the accept edge (cycle 1).
    task automatic wait_result(input string tag, input int exp_lat);
        int   cyc;
        logic rdy_seen;
        in_valid = 1'b0;
        cyc      = 1;
        rdy_seen = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (out_ready) rdy_seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (out_ready) rdy_seen = 1'b1;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_ready_busy"}, 64'(rdy_seen), 64'd0);
    endtask

    task automatic ack_result(input string tag);
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
        chk({tag, "_valid_after_ack"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sa, input logic sb);
        logic [N-1:0] eq, er;
        logic         ed;
        int           w;
        ref_div(a, b, sa, sb, eq, er, ed);
        @(negedge clk);
        drive_req(a, b, sa, sb);
        w = 0;
        while (!out_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_idle"}, 64'(out_ready), 64'd1);
        @(negedge clk);
        wait_result(tag, ed ? 1 : N + 2);
        chk({tag, "_q"}, 64'(out_quotient), 64'(eq));
        chk({tag, "_r"}, 64'(out_remainder), 64'(er));
        chk({tag, "_dz"}, 64'(out_div_by_zero), 64'(ed));
        ack_result(tag);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rsa, rsb;
        int           mode;

        rst_n              = 1'b0;
        in_valid           = 1'b0;
        in_ready           = 1'b0;
        in_dividend        = '0;
        in_divisor         = '0;
        in_dividend_signed = 1'b0;
        in_divisor_signed  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(out_ready), 64'd1);
        chk("rst_q", 64'(out_quotient), 64'd0);
        chk("rst_r", 64'(out_remainder), 64'd0);
        chk("rst_dz", 64'(out_div_by_zero), 64'd0);
        rst_n = 1'b1;

        run_op("u100_7",   32'd100,        32'd7,          1'b0, 1'b0);
        run_op("s-7_2",    32'hFFFFFFF9,   32'd2,          1'b1, 1'b1);
        run_op("s7_-2",    32'd7,          32'hFFFFFFFE,   1'b1, 1'b1);
        run_op("umax_1",   32'hFFFFFFFF,   32'd1,          1'b0, 1'b0);
        run_op("smin_-1",  32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b1);
        run_op("div0_5",   32'd5,          32'd0,          1'b0, 1'b0);
        run_op("div0_-5",  32'hFFFFFFFB,   32'd0,          1'b1, 1'b1);
        run_op("umix",     32'h80000000,   32'hFFFFFFFF,   1'b0, 1'b1);
        run_op("umsb_div", 32'hF0000000,   32'h90000000,   1'b0, 1'b0);

        // Backpressure in DONE with a new request pending.
        @(negedge clk);
        drive_req(32'd100, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        wait_result("bp_first", N + 2);
        drive_req(32'd50, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_ready", 64'(out_ready), 64'd0);
            chk("bp_hold_q", 64'(out_quotient), 64'd14);
            chk("bp_hold_r", 64'(out_remainder), 64'd2);
        end
        in_ready = 1'b1;
        @(negedge clk);
        in_ready = 1'b0;
        chk("bp_idle_ready", 64'(out_ready), 64'd1);
        chk("bp_idle_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("bp_accepted", 64'(out_ready), 64'd0);
        wait_result("bp_second", N + 2);
        chk("bp_second_q", 64'(out_quotient), 64'd16);
        chk("bp_second_r", 64'(out_remainder), 64'd2);
        ack_result("bp_second");

        // Randomized operands.
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 7);
            ra   = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            case (mode)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            rsa = 1'($urandom_range(0, 1));
            rsb = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), ra, rb, rsa, rsb);
        end

        // Reset in the middle of CALC after leaving nonzero outputs.
        run_op("pre_rst", 32'd100, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        drive_req(32'd12345678, 32'd3, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", 64'(out_quotient), 64'd0);
        chk("arst_r", 64'(out_remainder), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_dz", 64'(out_div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready", 64'(out_ready), 64'd1);
        chk("arst_no_result", 64'(out_valid), 64'd0);
        run_op("post_rst", 32'd1000, 32'd10, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
